// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM states and result-entry layout for the ALU command sequencer.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_MOD  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_EQ   = 4'h7;
  localparam logic [3:0] OP_LAND = 4'h8;
  localparam logic [3:0] OP_LOR  = 4'h9;
  localparam logic [3:0] OP_SHR2 = 4'hA;
  localparam logic [3:0] OP_SHL2 = 4'hB;
  localparam logic [3:0] OP_XOR  = 4'hC;
  localparam logic [3:0] OP_NOT  = 4'hD;
  localparam logic [3:0] OP_CAT  = 4'hE;
  localparam logic [3:0] OP_DUP  = 4'hF;

  // Frame parser / execute states
  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_A    = 2'd1,
    S_B    = 2'd2,
    S_EXEC = 2'd3
  } state_t;

  // Result entry: tag 4, err 1, cout 1, data 8
  localparam int ENTRY_W = 14;

  typedef struct packed {
    logic [3:0] tag;
    logic       err;
    logic       cout;
    logic [7:0] data;
  } result_t;

  // Opcodes whose divisor (operand B) must be nonzero
  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_res_fifo.sv
// Result FIFO with a registered first-word-fall-through head register.
// Entries land in the array first and move into the head register on the
// following edge, so the head output is always a register, never a RAM port.
module alu_res_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    mem_count_reg;   // entries still in the array (not yet at head)
  logic             head_valid_reg;
  logic [WIDTH-1:0] head_data_reg;

  logic push, pop, load;

  // Occupancy covers both the array and the head register
  assign count = mem_count_reg + CW'(head_valid_reg);
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  assign push = wr_en & ~full;
  assign pop  = head_valid_reg & rd_en;
  assign load = (~head_valid_reg | pop) & (mem_count_reg != '0);

  assign rd_data  = head_data_reg;
  assign rd_valid = head_valid_reg;

  // Array write port; storage needs no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= wr_data;
  end

  // Pointers, occupancy and head register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      mem_count_reg  <= '0;
      head_valid_reg <= 1'b0;
      head_data_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (load) begin
        rd_ptr_reg    <= rd_ptr_reg + AW'(1);
        head_data_reg <= mem[rd_ptr_reg];
      end
      mem_count_reg <= mem_count_reg + CW'(push) - CW'(load);
      if (load)     head_valid_reg <= 1'b1;
      else if (pop) head_valid_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Byte-serial command front end for the 8-bit ALU: parses header/A/B frames,
// drives registered operands, samples the ALU after a settle time and queues
// tagged results toward a valid/ready consumer.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int ALU_WAIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_sel,
  input  logic [7:0] alu_res,
  input  logic       alu_cout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_cout,
  output logic       out_err,
  output logic [3:0] out_tag,
  output logic       busy,
  output logic [7:0] cmd_count
);

  state_t     state_reg, state_next;
  logic [3:0] tag_reg;
  logic [7:0] a_reg, b_reg;
  logic [3:0] sel_reg;
  logic [3:0] wait_reg;
  logic [7:0] count_reg;
  logic       push;
  logic       accept;

  logic                  fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  result_t               entry, head;
  logic                  unused_fifo_status;

  assign accept    = in_valid & in_ready;
  assign alu_a     = a_reg;
  assign alu_b     = b_reg;
  assign alu_sel   = sel_reg;
  assign busy      = (state_reg != S_HDR);
  assign cmd_count = count_reg;

  assign unused_fifo_status = &{1'b0, fifo_empty, fifo_count};

  // Next-state, byte acceptance and push decision
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    push       = 1'b0;
    case (state_reg)
      S_HDR: begin
        in_ready = 1'b1;
        if (in_valid) state_next = S_A;
      end
      S_A: begin
        in_ready = 1'b1;
        if (in_valid) state_next = S_B;
      end
      S_B: begin
        in_ready = 1'b1;
        if (in_valid) state_next = S_EXEC;
      end
      S_EXEC: begin
        // Full check uses current occupancy; a same-cycle pop does not help
        if (wait_reg == 4'd0 && !fifo_full) begin
          push       = 1'b1;
          state_next = S_HDR;
        end
      end
      default: state_next = S_HDR;
    endcase
  end

  // Divide/modulo by zero replaces the ALU output with a flagged zero
  always_comb begin
    entry.tag = tag_reg;
    if (is_div_op(sel_reg) && b_reg == 8'd0) begin
      entry.err  = 1'b1;
      entry.cout = 1'b0;
      entry.data = 8'h00;
    end else begin
      entry.err  = 1'b0;
      entry.cout = alu_cout;
      entry.data = alu_res;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_HDR;
    else        state_reg <= state_next;
  end

  // Frame fields, settle counter and completed-command counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_reg   <= '0;
      sel_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      wait_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (accept) begin
        case (state_reg)
          S_HDR: begin
            tag_reg <= in_data[7:4];
            sel_reg <= in_data[3:0];
          end
          S_A:     a_reg <= in_data;
          S_B: begin
            b_reg    <= in_data;
            wait_reg <= 4'(ALU_WAIT);
          end
          default: ;
        endcase
      end
      if (state_reg == S_EXEC && wait_reg != 4'd0) wait_reg <= wait_reg - 4'd1;
      if (push) count_reg <= count_reg + 8'd1;
    end
  end

  alu_res_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (push),
    .wr_data  (entry),
    .rd_en    (out_ready),
    .rd_data  (head),
    .rd_valid (out_valid),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign out_data = head.data;
  assign out_cout = head.cout;
  assign out_err  = head.err;
  assign out_tag  = head.tag;

endmodule
